// File: rtl/median_filter_stream.sv
// Streaming sliding-window rank filter: median, min or max of the last WIN samples,
// with ready/valid handshakes and one registered output stage.
module median_filter_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WIN   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [1:0]                 mode,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(WIN+1)-1:0]   fill
);

  localparam int unsigned FW  = $clog2(WIN + 1);
  localparam int unsigned MED = (WIN - 1) / 2;

  generate
    if (WIN < 3 || WIN > 9 || (WIN % 2) == 0) begin : g_bad_win
      $error("median_filter_stream: WIN must be odd and within 3..9");
    end
  endgenerate

  logic [WIDTH-1:0] win  [WIN];
  logic [WIDTH-1:0] nwin [WIN];
  logic [WIDTH-1:0] sel;
  logic [FW-1:0]    rank;
  logic             accept;
  logic             post_full;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign post_full = (fill >= FW'(WIN - 1));

  // Post-shift window and target rank for the current mode
  always_comb begin
    nwin[0] = in_data;
    for (int k = 1; k < WIN; k++) begin
      nwin[k] = win[k-1];
    end
    case (mode)
      2'd1:    rank = '0;
      2'd2:    rank = FW'(WIN - 1);
      default: rank = FW'(MED);
    endcase
  end

  // Rank select: index ties resolve by position, so exactly one element matches
  always_comb begin
    logic [FW-1:0] cnt;
    sel = '0;
    cnt = '0;
    for (int i = 0; i < WIN; i++) begin
      cnt = '0;
      for (int j = 0; j < WIN; j++) begin
        if ((nwin[j] < nwin[i]) || ((nwin[j] == nwin[i]) && (j < i))) begin
          cnt = cnt + FW'(1);
        end
      end
      if (cnt == rank) begin
        sel = nwin[i];
      end
    end
  end

  // Window shift, fill count and registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < WIN; k++) begin
        win[k] <= '0;
      end
      fill      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      fill      <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        for (int k = 0; k < WIN; k++) begin
          win[k] <= nwin[k];
        end
        fill <= (fill == FW'(WIN)) ? fill : fill + FW'(1);
      end
      if (accept && post_full) begin
        out_valid <= 1'b1;
        out_data  <= sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_median_filter_stream.sv
// Scoreboard bench for median_filter_stream: a WIN=3 and a WIN=5 instance driven with
// directed vectors; monitors pop expected results on each output handshake.
module tb_median_filter_stream;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // WIN=3 instance signals
  logic       rst, clear, in_valid, out_ready, in_ready, out_valid;
  logic [1:0] mode;
  logic [7:0] in_data, out_data;
  logic [1:0] fill;

  // WIN=5 instance signals
  logic       rst5, clear5, in_valid5, out_ready5, in_ready5, out_valid5;
  logic [1:0] mode5;
  logic [7:0] in_data5, out_data5;
  logic [2:0] fill5;

  logic [7:0] q3[$];
  logic [7:0] q5[$];
  int n_cmp = 0;
  int n_err = 0;

  median_filter_stream #(.WIDTH(8), .WIN(3)) u3 (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fill(fill)
  );

  median_filter_stream #(.WIDTH(8), .WIN(5)) u5 (
    .clk(clk), .rst(rst5), .clear(clear5), .mode(mode5),
    .in_valid(in_valid5), .in_data(in_data5), .in_ready(in_ready5),
    .out_valid(out_valid5), .out_data(out_data5), .out_ready(out_ready5),
    .fill(fill5)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rst = 1'b0; clear = 1'b0; rst5 = 1'b0; clear5 = 1'b0;
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic rdy);
    in_valid = v; in_data = d; out_ready = rdy;
    tick();
  endtask

  task automatic cyc5(input logic v, input logic [7:0] d, input logic rdy);
    in_valid5 = v; in_data5 = d; out_ready5 = rdy;
    tick();
  endtask

  // Monitors: compare whenever the consumer takes a result
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (q3.size() == 0) begin
        n_err++;
        $display("FAIL u3_out: got %0d, required no output", out_data);
      end else begin
        logic [7:0] e;
        e = q3.pop_front();
        if (out_data !== e) begin
          n_err++;
          $display("FAIL u3_out: got %0d, required %0d", out_data, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst5 && out_valid5 && out_ready5) begin
      n_cmp++;
      if (q5.size() == 0) begin
        n_err++;
        $display("FAIL u5_out: got %0d, required no output", out_data5);
      end else begin
        logic [7:0] e;
        e = q5.pop_front();
        if (out_data5 !== e) begin
          n_err++;
          $display("FAIL u5_out: got %0d, required %0d", out_data5, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; mode = 2'd0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    rst5 = 1'b1; clear5 = 1'b0; mode5 = 2'd0; in_valid5 = 1'b0; in_data5 = '0; out_ready5 = 1'b0;
    cyc(0, 8'd0, 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_fill", int'(fill), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // Warm-up and slide
    cyc(1, 8'd1, 1);
    check("wu_fill1", int'(fill), 1);
    check("wu_valid1", int'(out_valid), 0);
    cyc(1, 8'd2, 1);
    check("wu_fill2", int'(fill), 2);
    check("wu_valid2", int'(out_valid), 0);
    q3.push_back(8'd2);
    cyc(1, 8'd4, 1);
    check("wu_fill3", int'(fill), 3);
    check("wu_first_valid", int'(out_valid), 1);
    check("wu_first_data", int'(out_data), 2);
    q3.push_back(8'd4);
    cyc(1, 8'd128, 1);
    check("wu_fill_sat", int'(fill), 3);
    cyc(0, 8'd0, 1);
    check("retire_valid", int'(out_valid), 0);

    // Ties and modes
    clear = 1'b1; cyc(0, 8'd0, 1);
    mode = 2'd0;
    cyc(1, 8'd5, 1); cyc(1, 8'd5, 1); q3.push_back(8'd5); cyc(1, 8'd3, 1);
    clear = 1'b1; mode = 2'd1; cyc(0, 8'd0, 1);
    cyc(1, 8'd5, 1); cyc(1, 8'd5, 1); q3.push_back(8'd3); cyc(1, 8'd3, 1);
    clear = 1'b1; mode = 2'd2; cyc(0, 8'd0, 1);
    cyc(1, 8'd5, 1); cyc(1, 8'd5, 1); q3.push_back(8'd5); cyc(1, 8'd3, 1);
    clear = 1'b1; mode = 2'd3; cyc(0, 8'd0, 1);
    cyc(1, 8'hFF, 1); cyc(1, 8'h00, 1); q3.push_back(8'h80); cyc(1, 8'h80, 1);
    mode = 2'd0;

    // Backpressure
    clear = 1'b1; cyc(0, 8'd0, 1);
    check("clr_fill", int'(fill), 0);
    cyc(1, 8'd10, 1); cyc(1, 8'd20, 1); q3.push_back(8'd20); cyc(1, 8'd30, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 8'd64, 0);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_valid", int'(out_valid), 1);
      check("bp_data", int'(out_data), 20);
      check("bp_fill", int'(fill), 3);
    end
    q3.push_back(8'd30); cyc(1, 8'd64, 1);
    q3.push_back(8'd64); cyc(1, 8'd64, 1);
    cyc(0, 8'd0, 1);

    // Back-to-back throughput
    clear = 1'b1; cyc(0, 8'd0, 1);
    cyc(1, 8'd1, 1); cyc(1, 8'd2, 1);
    q3.push_back(8'd2);  cyc(1, 8'd4, 1);
    q3.push_back(8'd4);  cyc(1, 8'd8, 1);
    q3.push_back(8'd8);  cyc(1, 8'd16, 1);
    check("tp_valid_held", int'(out_valid), 1);
    q3.push_back(8'd16); cyc(1, 8'd32, 1);
    q3.push_back(8'd32); cyc(1, 8'd64, 1);
    q3.push_back(8'd64); cyc(1, 8'd128, 1);
    cyc(0, 8'd0, 1);

    // Clear mid-stream drops the same-cycle sample
    clear = 1'b1; cyc(0, 8'd0, 1);
    cyc(1, 8'd7, 1); cyc(1, 8'd9, 1);
    check("mid_fill2", int'(fill), 2);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd200; out_ready = 1'b1;
    #1;
    check("clr_in_ready", int'(in_ready), 1);
    tick();
    check("clr_mid_fill", int'(fill), 0);
    check("clr_mid_valid", int'(out_valid), 0);
    cyc(1, 8'd50, 1); cyc(1, 8'd40, 1);
    check("clr_rewarm_valid", int'(out_valid), 0);
    check("clr_rewarm_fill", int'(fill), 2);
    cyc(1, 8'd60, 0);
    check("clr_result_valid", int'(out_valid), 1);
    check("clr_result_data", int'(out_data), 50);
    cyc(0, 8'd0, 0);
    check("hold_data", int'(out_data), 50);

    // Reset with a pending result
    rst = 1'b1; cyc(0, 8'd0, 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_data", int'(out_data), 0);
    check("mid_rst_fill", int'(fill), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    cyc(1, 8'd3, 1);
    check("rw_fill1", int'(fill), 1);
    cyc(1, 8'd1, 1);
    check("rw_valid2", int'(out_valid), 0);
    q3.push_back(8'd2); cyc(1, 8'd2, 1);
    check("rw_data", int'(out_data), 2);
    cyc(0, 8'd0, 1);

    // WIN=5 instance
    mode5 = 2'd0;
    cyc5(1, 8'd9, 1); cyc5(1, 8'd1, 1); cyc5(1, 8'd7, 1); cyc5(1, 8'd3, 1);
    check("w5_fill4", int'(fill5), 4);
    check("w5_warm_valid", int'(out_valid5), 0);
    q5.push_back(8'd5); cyc5(1, 8'd5, 1);
    q5.push_back(8'd5); cyc5(1, 8'd100, 1);
    check("w5_fill_sat", int'(fill5), 5);
    clear5 = 1'b1; cyc5(0, 8'd0, 1);
    cyc5(1, 8'd9, 1); cyc5(1, 8'd1, 1); cyc5(1, 8'd7, 1); cyc5(1, 8'd3, 1);
    q5.push_back(8'd5); cyc5(1, 8'd5, 1);
    mode5 = 2'd2; q5.push_back(8'd100); cyc5(1, 8'd100, 1);
    mode5 = 2'd1; q5.push_back(8'd2); cyc5(1, 8'd2, 1);
    cyc5(0, 8'd0, 1);

    // Drain with a bounded wait
    for (int i = 0; i < 20; i++) begin
      if (q3.size() == 0 && q5.size() == 0) break;
      cyc(0, 8'd0, 1);
    end
    check("q3_drained", q3.size(), 0);
    check("q5_drained", q5.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
